// File: rtl/qpsk_frame_scheduler.sv
// Frame sequencer feeding the QPSK modulator: preamble, MSB-first payload dibits, idle gap.
// Define QPSK_PILOT_EN to insert a 2'b00 pilot after every PILOT_PERIOD payload symbols.
`timescale 1ns/1ps

module qpsk_frame_scheduler #(
  parameter int SYM_DIV      = 4,
  parameter int PRE_LEN      = 8,
  parameter int GAP_LEN      = 2,
  parameter int PILOT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic [1:0] sym_o,
  output logic       sym_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SYM_DIV - 1);
  localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);
  // A misparameterised instance never leaves IDLE instead of emitting a malformed frame.
  localparam bit CFG_OK = (SYM_DIV >= 2) && (PRE_LEN >= 1) && (GAP_LEN >= 1) && (PILOT_PERIOD >= 1);

  state_t      state_q, state_n;
  logic [15:0] per_q, per_n;
  logic [15:0] tcnt_q, tcnt_n;
  logic [9:0]  pay_q, pay_n;
  logic [7:0]  len_q, len_n;
  logic [7:0]  acc_q, acc_n;
  logic [7:0]  sh_q, sh_n;
  logic [2:0]  shc_q, shc_n;
  logic [7:0]  hold_q, hold_n;
  logic        hvld_q, hvld_n;
  logic        ready_n;
  logic [1:0]  sym_n;
  logic        sym_vld_n, busy_n, done_n, under_n;
`ifdef QPSK_PILOT_EN
  logic [15:0] pil_q, pil_n;
  logic        pdue_q, pdue_n;
`endif

  logic       tick, xfer, use_hold, is_last;
  logic [7:0] eff_sh;
  logic [2:0] eff_cnt;
  logic [9:0] last_idx;

  assign tick     = (state_q != S_IDLE) && (per_q == DIV_LAST);
  assign xfer     = byte_valid_i && byte_ready_o;
  // An exhausted shift register reads straight through the holding register, so a
  // byte that landed just before a tick is never reported as an underrun.
  assign use_hold = (shc_q == 3'd0) && hvld_q;
  assign eff_sh   = use_hold ? hold_q : sh_q;
  assign eff_cnt  = use_hold ? 3'd4 : shc_q;
  assign last_idx = {len_q, 2'b00} - 10'd1;
  assign is_last  = (pay_q == last_idx);

  // NOTE: every variable gets its default before any branch, so no path can infer a latch.
  always_comb begin
    state_n   = state_q;
    per_n     = (state_q == S_IDLE || tick) ? 16'd0 : per_q + 16'd1;
    tcnt_n    = tcnt_q;
    pay_n     = pay_q;
    len_n     = len_q;
    acc_n     = acc_q;
    sh_n      = eff_sh;
    shc_n     = eff_cnt;
    hold_n    = hold_q;
    hvld_n    = hvld_q && !use_hold;
    sym_n     = sym_o;
    sym_vld_n = 1'b0;
    done_n    = 1'b0;
    under_n   = 1'b0;
`ifdef QPSK_PILOT_EN
    pil_n     = pil_q;
    pdue_n    = pdue_q;
`endif

    if (xfer) begin
      hold_n = byte_i;
      hvld_n = 1'b1;
      acc_n  = acc_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i && (len_i != 8'd0) && CFG_OK) begin
          state_n = S_PRE;
          len_n   = len_i;
          acc_n   = 8'd0;
          tcnt_n  = 16'd0;
          pay_n   = 10'd0;
          sh_n    = 8'd0;
          shc_n   = 3'd0;
          hold_n  = 8'd0;
          hvld_n  = 1'b0;
`ifdef QPSK_PILOT_EN
          pil_n   = 16'd0;
          pdue_n  = 1'b0;
`endif
        end
      end

      S_PRE: begin
        if (tick) begin
          sym_n     = tcnt_q[0] ? 2'b11 : 2'b00;
          sym_vld_n = 1'b1;
          if (tcnt_q == PRE_LAST) begin
            state_n = S_PAY;
            tcnt_n  = 16'd0;
          end else begin
            tcnt_n = tcnt_q + 16'd1;
          end
        end
      end

      S_PAY: begin
        if (tick) begin
`ifdef QPSK_PILOT_EN
          if (pdue_q) begin
            sym_n     = 2'b00;
            sym_vld_n = 1'b1;
            pdue_n    = 1'b0;
          end else
`endif
          if (eff_cnt != 3'd0) begin
            sym_n     = eff_sh[7:6];
            sym_vld_n = 1'b1;
            sh_n      = {eff_sh[5:0], 2'b00};
            shc_n     = eff_cnt - 3'd1;
            pay_n     = pay_q + 10'd1;
`ifdef QPSK_PILOT_EN
            if ((pil_q + 16'd1 == 16'(PILOT_PERIOD)) && !is_last) begin
              pil_n  = 16'd0;
              pdue_n = 1'b1;
            end else begin
              pil_n = pil_q + 16'd1;
            end
`endif
            if (is_last) begin
              state_n = S_GAP;
              tcnt_n  = 16'd0;
            end
          end else begin
            // Nothing to send: stretch the frame by one period rather than corrupt it.
            under_n = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            tcnt_n = tcnt_q + 16'd1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n  = (state_n != S_IDLE);
    // Ready is registered from next-state values, so it always equals the live condition.
    ready_n = ((state_n == S_PRE) || (state_n == S_PAY)) && !hvld_n && (acc_n < len_n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the byte buffers are cleared too, so an aborted frame leaves no stale data.
      state_q      <= S_IDLE;
      per_q        <= '0;
      tcnt_q       <= '0;
      pay_q        <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      sh_q         <= '0;
      shc_q        <= '0;
      hold_q       <= '0;
      hvld_q       <= 1'b0;
      byte_ready_o <= 1'b0;
      sym_o        <= 2'b00;
      sym_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      underrun_o   <= 1'b0;
`ifdef QPSK_PILOT_EN
      pil_q        <= '0;
      pdue_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      per_q        <= per_n;
      tcnt_q       <= tcnt_n;
      pay_q        <= pay_n;
      len_q        <= len_n;
      acc_q        <= acc_n;
      sh_q         <= sh_n;
      shc_q        <= shc_n;
      hold_q       <= hold_n;
      hvld_q       <= hvld_n;
      byte_ready_o <= ready_n;
      sym_o        <= sym_n;
      sym_valid_o  <= sym_vld_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      underrun_o   <= under_n;
`ifdef QPSK_PILOT_EN
      pil_q        <= pil_n;
      pdue_q       <= pdue_n;
`endif
    end
  end

endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Directed bench for qpsk_frame_scheduler (default parameters); expectations follow
// QPSK_PILOT_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_qpsk_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] len_i;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;
  logic [1:0] sym_o;
  logic       sym_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;

  qpsk_frame_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .sym_o        (sym_o),
    .sym_valid_o  (sym_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

`ifdef QPSK_PILOT_EN
  localparam int N_PILOT = 1;
`else
  localparam int N_PILOT = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Edge counter: sampled on a falling edge it equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] sq[$];
  int         sc[$];
  int         n_under = 0;
  bit         both_hi = 1'b0;

  always @(negedge clk) begin
    if (sym_valid_o === 1'b1) begin
      sq.push_back(sym_o);
      sc.push_back(cyc);
    end
    if (underrun_o === 1'b1) n_under++;
    if (sym_valid_o === 1'b1 && underrun_o === 1'b1) both_hi = 1'b1;
  end

  // Starts a frame; on return we sit at the falling edge just after E0.
  task automatic start_frame(input logic [7:0] len, output int e0);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = len;
    e0      = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] v);
    int n;
    n = 0;
    byte_i       = v;
    byte_valid_i = 1'b1;
    while (byte_ready_o !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    int n;
    at = -1;
    n  = 0;
    while (at < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (done_o === 1'b1) at = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; len_i = 8'd0; byte_i = 8'd0; byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", byte_ready_o); end
    vectors++; if (sym_o !== 2'b00) begin miscompares++; $display("FAIL reset_sym got %b want 00", sym_o); end
    vectors++; if (sym_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sym_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_o); end
    vectors++; if (underrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got %b want 0", underrun_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // len=1 with byte 0xB4; optionally pulses start_i mid-frame, which must change nothing.
  task automatic run_single(input string tag, input bit poke_start);
    logic [1:0] exp [12];
    int e0, d, b;
    exp = '{2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
    b = sq.size();
    start_frame(8'd1, e0);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL %s_busy_rise got %b want 1", tag, busy_o); end
    feed_byte(8'hB4);
    if (poke_start) begin
      repeat (10) @(negedge clk);
      start_i = 1'b1; len_i = 8'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (25) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(300, d);
    vectors++; if (d !== e0 + 56) begin miscompares++; $display("FAIL %s_done_edge got %0d want %0d", tag, d - e0, 56); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL %s_busy_fall got %b want 0", tag, busy_o); end
    vectors++; if (sq.size() - b !== 12) begin miscompares++; $display("FAIL %s_strobes got %0d want 12", tag, sq.size() - b); end
    for (int k = 0; k < 12; k++) begin
      if (b + k < sq.size()) begin
        vectors++;
        if (sq[b+k] !== exp[k] || sc[b+k] !== e0 + 4*(k+1)) begin
          miscompares++;
          $display("FAIL %s_sym%0d got %b@%0d want %b@%0d", tag, k, sq[b+k], sc[b+k] - e0, exp[k], 4*(k+1));
        end
      end
    end
  endtask

  task automatic test_single_byte();
    run_single("single", 1'b0);
  endtask

  task automatic test_pilot();
    logic [7:0] bytes [5];
    logic [1:0] exp[$];
    int e0, d, b;
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int k = 0; k < 8; k++) exp.push_back(k[0] ? 2'b11 : 2'b00);
    for (int i = 0; i < 5; i++) begin
      for (int j = 3; j >= 0; j--) begin
        exp.push_back(bytes[i][2*j +: 2]);
        if (N_PILOT == 1 && i == 3 && j == 0) exp.push_back(2'b00);
      end
    end
    b = sq.size();
    start_frame(8'd5, e0);
    for (int i = 0; i < 5; i++) feed_byte(bytes[i]);
    wait_done(500, d);
    vectors++; if (d !== e0 + 4*(30 + N_PILOT)) begin miscompares++; $display("FAIL pilot_done_edge got %0d want %0d", d - e0, 4*(30 + N_PILOT)); end
    vectors++; if (sq.size() - b !== 28 + N_PILOT) begin miscompares++; $display("FAIL pilot_strobes got %0d want %0d", sq.size() - b, 28 + N_PILOT); end
    for (int k = 0; k < exp.size(); k++) begin
      if (b + k < sq.size()) begin
        vectors++;
        if (sq[b+k] !== exp[k]) begin miscompares++; $display("FAIL pilot_sym%0d got %b want %b", k, sq[b+k], exp[k]); end
      end
    end
  endtask

  task automatic test_underrun();
    logic [1:0] exp [16];
    int e0, d, b, u, n;
    exp = '{2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11,
            2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
    b = sq.size();
    u = n_under;
    both_hi = 1'b0;
    start_frame(8'd2, e0);
    feed_byte(8'hFF);
    n = 0;
    while (sq.size() - b < 12 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    feed_byte(8'h1E);
    wait_done(300, d);
    vectors++; if (n_under - u !== 5) begin miscompares++; $display("FAIL underrun_pulses got %0d want 5", n_under - u); end
    vectors++; if (both_hi !== 1'b0) begin miscompares++; $display("FAIL underrun_with_valid got %b want 0", both_hi); end
    vectors++; if (d !== e0 + 92) begin miscompares++; $display("FAIL underrun_done_edge got %0d want 92", d - e0); end
    vectors++; if (sq.size() - b !== 16) begin miscompares++; $display("FAIL underrun_strobes got %0d want 16", sq.size() - b); end
    if (b + 12 < sq.size()) begin
      vectors++;
      if (sc[b+12] !== e0 + 72) begin miscompares++; $display("FAIL underrun_resume_edge got %0d want 72", sc[b+12] - e0); end
    end
    for (int k = 0; k < 16; k++) begin
      if (b + k < sq.size()) begin
        vectors++;
        if (sq[b+k] !== exp[k]) begin miscompares++; $display("FAIL underrun_sym%0d got %b want %b", k, sq[b+k], exp[k]); end
      end
    end
  endtask

  task automatic test_ignored_start();
    int b, e0;
    b = sq.size();
    start_frame(8'd0, e0);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_len_busy got %b want 0", busy_o); end
    vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL zero_len_ready got %b want 0", byte_ready_o); end
    repeat (8) @(negedge clk);
    vectors++; if (sq.size() - b !== 0) begin miscompares++; $display("FAIL zero_len_strobes got %0d want 0", sq.size() - b); end
    run_single("midstart", 1'b1);
  endtask

  task automatic test_reset_mid_payload();
    int e0, b, n, dones;
    b = sq.size();
    start_frame(8'd2, e0);
    feed_byte(8'hC3);
    n = 0;
    while (sq.size() - b < 9 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", byte_ready_o); end
    vectors++; if (sym_o !== 2'b00) begin miscompares++; $display("FAIL abort_sym got %b want 00", sym_o); end
    vectors++; if (sym_valid_o !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", sym_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy_o); end
    vectors++; if (underrun_o !== 1'b0) begin miscompares++; $display("FAIL abort_underrun got %b want 0", underrun_o); end
    rst = 1'b1;
    dones = (done_o === 1'b1) ? 1 : 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL abort_done_pulses got %0d want 0", dones); end
    run_single("after_abort", 1'b0);
  endtask

  task automatic test_back_to_back();
    int e0, d1, d2, b;
    b = sq.size();
    byte_i       = 8'hB4;
    byte_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 8'd1;
    e0      = cyc + 1;
    wait_done(300, d1);
    @(negedge clk);
    start_i = 1'b0;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_second_busy got %b want 1", busy_o); end
    wait_done(300, d2);
    byte_valid_i = 1'b0;
    vectors++; if (d1 !== e0 + 56) begin miscompares++; $display("FAIL b2b_done1_edge got %0d want 56", d1 - e0); end
    vectors++; if (d2 !== d1 + 57) begin miscompares++; $display("FAIL b2b_done2_gap got %0d want 57", d2 - d1); end
    vectors++; if (sq.size() - b !== 24) begin miscompares++; $display("FAIL b2b_strobes got %0d want 24", sq.size() - b); end
    if (b + 12 < sq.size()) begin
      vectors++;
      if (sc[b+12] !== d1 + 5 || sq[b+12] !== 2'b00) begin
        miscompares++;
        $display("FAIL b2b_second_first got %b@%0d want 00@%0d", sq[b+12], sc[b+12] - d1, 5);
      end
    end
    if (b + 23 < sq.size()) begin
      vectors++;
      if (sq[b+23] !== 2'b00 || sq[b+20] !== 2'b10) begin
        miscompares++;
        $display("FAIL b2b_second_payload got %b..%b want 10..00", sq[b+20], sq[b+23]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_pilot();
    test_underrun();
    test_ignored_start();
    test_reset_mid_payload();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
